// File: rtl/pillow_drop_ctrl_if.sv
// Signal bundle between the pillow drop controller and its consumers
// (keyboard/collision inputs in, pillow geometry and game status out).
interface pillow_drop_ctrl_if;
   logic [7:0]  scan_code;
   logic        fail;
   logic [10:0] pillow_column_begin;
   logic [10:0] pillow_column_end;
   logic [10:0] pillow_row_begin;
   logic [10:0] pillow_row_end;
   logic        pillow_active;
   logic [7:0]  dodges;
   logic [3:0]  speed;

   modport master (
      input  scan_code,
      input  fail,
      output pillow_column_begin,
      output pillow_column_end,
      output pillow_row_begin,
      output pillow_row_end,
      output pillow_active,
      output dodges,
      output speed
   );

   modport slave (
      output scan_code,
      output fail,
      input  pillow_column_begin,
      input  pillow_column_end,
      input  pillow_row_begin,
      input  pillow_row_end,
      input  pillow_active,
      input  dodges,
      input  speed
   );
endinterface

// File: rtl/pillow_drop_ctrl.sv
// Falling-pillow generator: spawns at a pseudo-random column, drops once per frame tick,
// speeds up as dodges accumulate, freezes on fail and restarts on ENTER.
module pillow_drop_ctrl #(
   parameter int SCREEN_W    = 800,
   parameter int SCREEN_H    = 600,
   parameter int PILLOW_W    = 40,
   parameter int PILLOW_H    = 40,
   parameter int TICK_DIV    = 833333,
   parameter int START_SPEED = 2,
   parameter int MAX_SPEED   = 8,
   parameter int SPEED_STEP  = 4
) (
   input  logic               clk,
   input  logic               resetn,
   pillow_drop_ctrl_if.master bus
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(SPEED_STEP - 1);
   localparam logic [10:0]   ROW_OFF   = 11'(SCREEN_H);
   localparam logic [10:0]   COL_SPAN  = 11'(SCREEN_W - PILLOW_W);
   localparam logic [10:0]   W_M1      = 11'(PILLOW_W - 1);
   localparam logic [10:0]   H_M1      = 11'(PILLOW_H - 1);
   localparam logic [3:0]    SPD_INIT  = 4'(START_SPEED);
   localparam logic [3:0]    SPD_MAX   = 4'(MAX_SPEED);
   localparam logic [7:0]    KEY_ENTER = 8'h5A;
   localparam logic [15:0]   LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPAWN = 2'd1,
      ST_FALL  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t        state_r;
   logic [TW-1:0] tick_cnt_r;
   logic [15:0]   lfsr_r;
   logic [10:0]   col_r;
   logic [10:0]   row_r;
   logic          active_r;
   logic [7:0]    dodges_r;
   logic [3:0]    speed_r;
   logic [SW-1:0] step_cnt_r;

   logic          tick_s;
   logic          enter_s;
   logic [10:0]   row_next_s;
   logic [10:0]   col_spawn_s;

   // Taps 16,14,13,11 in right-shift form; a nonzero seed never reaches all-zero.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      lfsr_step = {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
   endfunction

   // Folds the raw 10-bit value back into the legal left-edge range.
   function automatic logic [10:0] spawn_column(input logic [9:0] raw);
      logic [10:0] wide;
      wide = {1'b0, raw};
      if (wide > COL_SPAN) begin
         spawn_column = wide - COL_SPAN;
      end else begin
         spawn_column = wide;
      end
   endfunction

   // Decode of tick, ENTER, next fall row and candidate spawn column.
   always_comb begin
      tick_s      = (tick_cnt_r == TICK_LAST);
      enter_s     = (bus.scan_code == KEY_ENTER);
      row_next_s  = row_r + {7'd0, speed_r};
      col_spawn_s = spawn_column(lfsr_r[9:0]);
   end

   // Frame-tick divider and LFSR, free-running in every state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tick_cnt_r <= '0;
         lfsr_r     <= LFSR_SEED;
      end else begin
         if (tick_s) begin
            tick_cnt_r <= '0;
         end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
         end
         lfsr_r <= lfsr_step(lfsr_r);
      end
   end

   // Game state machine with all pillow/status outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         col_r      <= 11'd0;
         row_r      <= ROW_OFF;
         active_r   <= 1'b0;
         dodges_r   <= 8'd0;
         speed_r    <= SPD_INIT;
         step_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (enter_s) begin
                  state_r <= ST_SPAWN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SPAWN: begin
               col_r    <= col_spawn_s;
               row_r    <= 11'd0;
               active_r <= 1'b1;
               state_r  <= ST_FALL;
            end
            ST_FALL: begin
               // A collision wins over a same-cycle tick so the frozen frame shows the hit.
               if (bus.fail) begin
                  active_r <= 1'b0;
                  state_r  <= ST_HALT;
               end else if (tick_s && (row_next_s >= ROW_OFF)) begin
                  row_r    <= ROW_OFF;
                  active_r <= 1'b0;
                  state_r  <= ST_SPAWN;
                  if (dodges_r != 8'hFF) begin
                     dodges_r <= dodges_r + 8'd1;
                  end else begin
                     dodges_r <= dodges_r;
                  end
                  if (step_cnt_r == STEP_LAST) begin
                     step_cnt_r <= '0;
                     if (speed_r < SPD_MAX) begin
                        speed_r <= speed_r + 4'd1;
                     end else begin
                        speed_r <= SPD_MAX;
                     end
                  end else begin
                     step_cnt_r <= step_cnt_r + SW'(1);
                  end
               end else if (tick_s) begin
                  row_r <= row_next_s;
               end else begin
                  row_r <= row_r;
               end
            end
            ST_HALT: begin
               if (enter_s) begin
                  dodges_r   <= 8'd0;
                  speed_r    <= SPD_INIT;
                  step_cnt_r <= '0;
                  state_r    <= ST_SPAWN;
               end else begin
                  state_r <= ST_HALT;
               end
            end
            default: begin
               active_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pillow_column_begin = col_r;
   assign bus.pillow_column_end   = col_r + W_M1;
   assign bus.pillow_row_begin    = row_r;
   assign bus.pillow_row_end      = row_r + H_M1;
   assign bus.pillow_active       = active_r;
   assign bus.dodges              = dodges_r;
   assign bus.speed               = speed_r;

endmodule

// File: tb/tb_pillow_drop_ctrl.sv
// Scoreboard bench for pillow_drop_ctrl: stimulus queues the expected output events,
// a negedge monitor pops one expected record per observed change of the outputs.
module tb_pillow_drop_ctrl;

   localparam int          TICK_DIV = 4;
   localparam int          COL_MAX  = 760;
   localparam logic [7:0]  ENTER    = 8'h5A;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   pillow_drop_ctrl_if bus ();

   pillow_drop_ctrl #(
      .SCREEN_W(800), .SCREEN_H(600), .PILLOW_W(40), .PILLOW_H(40),
      .TICK_DIV(TICK_DIV), .START_SPEED(2), .MAX_SPEED(8), .SPEED_STEP(4)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // colm: 0 = range only, 1 = column from the LFSR value of the spawn cycle, 2 = zero
   typedef struct {
      int    row;
      bit    act;
      int    dod;
      int    spd;
      int    colm;
      int    cyc;
      bit    tmove;
      string tag;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] lfsr_m;
   logic [15:0] lfsr_prev;
   int          tcnt_m;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference LFSR and tick phase, reset together with the DUT.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_m    <= 16'hACE1;
         lfsr_prev <= 16'hACE1;
         tcnt_m    <= 0;
      end else begin
         lfsr_prev <= lfsr_m;
         lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
         tcnt_m    <= (tcnt_m == TICK_DIV - 1) ? 0 : tcnt_m + 1;
      end
   end

   function automatic int spawn_col(input logic [15:0] l);
      int c;
      c = int'(l[9:0]);
      if (c > COL_MAX) c = c - COL_MAX;
      return c;
   endfunction

   function automatic int spd_for(input int d);
      int s;
      s = 2 + d / 4;
      return (s > 8) ? 8 : s;
   endfunction

   task automatic push(input int row, input bit act, input int dod, input int spd,
                       input int colm, input int ecyc, input bit tm, input string tag);
      exp_t e;
      e.row = row; e.act = act; e.dod = dod; e.spd = spd;
      e.colm = colm; e.cyc = ecyc; e.tmove = tm; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_%s: %0d expected events still pending after %0d cycles, want 0",
                  tag, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   // Monitor: every change of row/active/dodges/speed is one output event.
   initial begin : monitor
      exp_t        e;
      logic [10:0] p_row;
      logic        p_act;
      logic [7:0]  p_dod;
      logic [3:0]  p_spd;
      bit          ok;
      int          want_col;
      p_row = 11'h7FF;
      p_act = 1'b0;
      p_dod = 8'hFF;
      p_spd = 4'hF;
      forever begin
         @(negedge clk);
         if (bus.pillow_row_begin !== p_row || bus.pillow_active !== p_act ||
             bus.dodges !== p_dod || bus.speed !== p_spd) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: got row=%0d act=%0b dod=%0d spd=%0d at cyc %0d, want no change",
                        bus.pillow_row_begin, bus.pillow_active, bus.dodges, bus.speed, cyc);
            end else begin
               e = exp_q.pop_front();
               want_col = (e.colm == 1) ? spawn_col(lfsr_prev) : 0;
               ok = (bus.pillow_row_begin === 11'(e.row)) && (bus.pillow_active === e.act) &&
                    (bus.dodges === 8'(e.dod)) && (bus.speed === 4'(e.spd)) &&
                    (bus.pillow_column_end === bus.pillow_column_begin + 11'd39) &&
                    (bus.pillow_row_end === bus.pillow_row_begin + 11'd39) &&
                    (bus.pillow_column_begin <= 11'(COL_MAX)) &&
                    (dut.lfsr_r === lfsr_m) &&
                    (e.colm == 0 || bus.pillow_column_begin === 11'(want_col)) &&
                    (e.cyc < 0 || cyc == e.cyc) &&
                    (!e.tmove || tcnt_m == 0);
               if (!ok) begin
                  errors++;
                  $display("FAIL %s: got row=%0d act=%0b dod=%0d spd=%0d col=%0d cend=%0d rend=%0d lfsr=%h cyc=%0d tphase=%0d; want row=%0d act=%0b dod=%0d spd=%0d colm=%0d col=%0d lfsr=%h cyc=%0d tick_edge=%0b",
                           e.tag, bus.pillow_row_begin, bus.pillow_active, bus.dodges, bus.speed,
                           bus.pillow_column_begin, bus.pillow_column_end, bus.pillow_row_end,
                           dut.lfsr_r, cyc, tcnt_m, e.row, e.act, e.dod, e.spd, e.colm, want_col,
                           lfsr_m, e.cyc, e.tmove);
               end
            end
         end
         p_row = bus.pillow_row_begin;
         p_act = bus.pillow_active;
         p_dod = bus.dodges;
         p_spd = bus.speed;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.scan_code = 8'h00;
      bus.fail      = 1'b0;

      push(600, 1'b0, 0, 2, 2, -1, 1'b0, "reset_state");
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      wait_drain(5, "reset");

      // First game: spawn two clocks after ENTER, full fall at speed 2, then fall to row 100.
      @(negedge clk);
      push(0, 1'b1, 0, 2, 1, cyc + 2, 1'b0, "first_spawn");
      for (int r = 2; r < 600; r += 2) push(r, 1'b1, 0, 2, 0, -1, 1'b1, "fall_s2");
      push(600, 1'b0, 1, 2, 0, -1, 1'b1, "first_dodge");
      push(0, 1'b1, 1, 2, 1, -1, 1'b0, "respawn");
      for (int r = 2; r <= 100; r += 2) push(r, 1'b1, 1, 2, 0, -1, 1'b1, "fall_to_100");
      bus.scan_code = ENTER;
      @(negedge clk);
      bus.scan_code = 8'h00;
      wait_drain(2000, "first_game");

      // Collision on the same clock as a tick: row must stay at 100.
      begin
         int n;
         n = 0;
         while (tcnt_m != TICK_DIV - 1 && n < 8) begin
            @(negedge clk);
            n++;
         end
      end
      push(100, 1'b0, 1, 2, 0, cyc + 1, 1'b0, "fail_beats_tick");
      bus.fail = 1'b1;
      @(negedge clk);
      bus.fail = 1'b0;
      wait_drain(4, "halt");
      repeat (6) @(negedge clk);

      push(100, 1'b0, 0, 2, 0, cyc + 1, 1'b0, "restart_clears");
      push(0, 1'b1, 0, 2, 1, cyc + 2, 1'b0, "restart_spawn");
      bus.scan_code = ENTER;
      @(negedge clk);
      bus.scan_code = 8'h00;

      // Thirty dodges: speed ramps every fourth dodge and stops at 8.
      for (int d = 0; d < 30; d++) begin
         int s;
         int s2;
         s  = spd_for(d);
         s2 = spd_for(d + 1);
         for (int r = s; r < 600; r += s) push(r, 1'b1, d, s, 0, -1, 1'b1, "fall_ramp");
         push(600, 1'b0, d + 1, s2, 0, -1, 1'b1, "dodge");
         push(0, 1'b1, d + 1, s2, 1, -1, 1'b0, "spawn_ramp");
      end
      for (int r = 8; r <= 32; r += 8) push(r, 1'b1, 30, 8, 0, -1, 1'b1, "fall_s8");
      wait_drain(20000, "ramp");

      // ENTER while falling is ignored; the next event is a normal step.
      push(40, 1'b1, 30, 8, 0, -1, 1'b1, "enter_ignored");
      bus.scan_code = ENTER;
      @(negedge clk);
      bus.scan_code = 8'h00;
      wait_drain(8, "enter_ignored");

      push(600, 1'b0, 0, 2, 2, -1, 1'b0, "async_reset");
      @(posedge clk);
      #2 resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      wait_drain(2, "async_reset");

      // Many spawn/halt cycles to exercise the column fold and LFSR sequence.
      for (int i = 0; i < 1000; i++) begin
         push(0, 1'b1, 0, 2, 1, cyc + 2, 1'b0, "spawn_col");
         bus.scan_code = ENTER;
         @(negedge clk);
         bus.scan_code = 8'h00;
         @(negedge clk);
         push(0, 1'b0, 0, 2, 0, cyc + 1, 1'b0, "halt_col");
         bus.fail = 1'b1;
         @(negedge clk);
         bus.fail = 1'b0;
      end
      wait_drain(4, "spawns");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
